// File: rtl/pot_rd_ctrl_if.sv
// Request/response and SPI pin bundle for the MCP41HVX1 read master.
// The slave modport is the controller's view; master is the surrounding environment.
interface pot_rd_ctrl_if;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       pot_busy;
  logic       rd_active;
  logic       rd_busy;
  logic       rd_done;
  logic [8:0] rd_data;
  logic       rd_err;
  logic       pot_cs_;
  logic       pot_sclk;
  logic       pot_mosi;
  logic       pot_miso;

  modport slave (
    input  rd_req, rd_addr, pot_busy, pot_miso,
    output rd_active, rd_busy, rd_done, rd_data, rd_err, pot_cs_, pot_sclk, pot_mosi
  );

  modport master (
    output rd_req, rd_addr, pot_busy, pot_miso,
    input  rd_active, rd_busy, rd_done, rd_data, rd_err, pot_cs_, pot_sclk, pot_mosi
  );
endinterface

// File: rtl/pot_rd_ctrl.sv
// SPI mode-0 read master for the MCP41HVX1 pot: sends a 16-bit Read Data command and
// captures the 9-bit register value, flagging CMDERR.
module pot_rd_ctrl #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_,
  pot_rd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBus,
    StCsSetup,
    StShiftHi,
    StShiftLo,
    StCsHold,
    StCsGap
  } state_e;

  localparam logic [7:0] CntMax = 8'(HALF_DIV - 1);

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [15:0] r_tx;
  logic [9:0]  r_rx;

  logic        r_rd_active, r_rd_busy, r_rd_done, r_rd_err;
  logic [8:0]  r_rd_data;
  logic        r_cs_n, r_sclk, r_mosi;

  logic w_accept, w_phase_end, w_timed, w_frame;
  logic w_active_d, w_cs_n_d, w_sclk_d, w_mosi_d, w_busy_d, w_done_d;

  assign w_accept    = (r_state == StIdle) && bus.rd_req && !r_rd_busy;
  assign w_phase_end = (r_cnt == CntMax);
  assign w_timed     = (r_state != StIdle) && (r_state != StWaitBus);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_nxt = bus.pot_busy ? StWaitBus : StCsSetup;
      StWaitBus: if (!bus.pot_busy) w_state_nxt = StCsSetup;
      StCsSetup: if (w_phase_end) w_state_nxt = StShiftHi;
      StShiftHi: if (w_phase_end) w_state_nxt = StShiftLo;
      StShiftLo: if (w_phase_end) w_state_nxt = (r_bit == 5'd16) ? StCsHold : StShiftHi;
      StCsHold:  if (w_phase_end) w_state_nxt = StCsGap;
      StCsGap:   if (w_phase_end) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_timed || (w_state_nxt != r_state)) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + 8'd1;
      if (w_accept) begin
        r_tx  <= {bus.rd_addr, 2'b11, 10'h3FF};
        r_bit <= '0;
      end else if ((r_state == StShiftHi) && w_phase_end) begin
        r_tx  <= {r_tx[14:0], 1'b0};
        r_bit <= r_bit + 5'd1;
      end
      // Sample on the edge where the registered SCLK goes high; only the last 10 bits matter.
      if ((r_state == StShiftHi) && (r_cnt == '0)) r_rx <= {r_rx[8:0], bus.pot_miso};
    end
  end

  // Outputs are registered one cycle behind the state they decode.
  always_comb begin
    w_frame    = (r_state == StCsSetup) || (r_state == StShiftHi) || (r_state == StShiftLo);
    w_active_d = w_timed;
    w_cs_n_d   = !(w_frame || (r_state == StCsHold));
    w_sclk_d   = (r_state == StShiftHi);
    w_mosi_d   = w_frame && r_tx[15];
    w_busy_d   = (r_state != StIdle) || w_accept;
    w_done_d   = (r_state == StIdle) && r_rd_busy;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rd_active <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rd_data   <= '0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_rd_active <= w_active_d;
      r_rd_busy   <= w_busy_d;
      r_rd_done   <= w_done_d;
      r_cs_n      <= w_cs_n_d;
      r_sclk      <= w_sclk_d;
      r_mosi      <= w_mosi_d;
      if (w_done_d) begin
        if (r_rx[9]) begin
          r_rd_data <= r_rx[8:0];
          r_rd_err  <= 1'b0;
        end else begin
          r_rd_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_active = r_rd_active;
  assign bus.rd_busy   = r_rd_busy;
  assign bus.rd_done   = r_rd_done;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_err    = r_rd_err;
  assign bus.pot_cs_   = r_cs_n;
  assign bus.pot_sclk  = r_sclk;
  assign bus.pot_mosi  = r_mosi;

endmodule

// File: tb/tb_pot_rd_ctrl.sv
// Bench for pot_rd_ctrl: pin-level pot model, transaction-timeline reference and
// per-cycle comparison, with directed frames followed by random traffic.
module tb_pot_rd_ctrl;
  localparam int H = 4;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  pot_rd_ctrl_if bus ();

  pot_rd_ctrl #(.HALF_DIV(H)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n      = 0;
  int n_vec  = 0;
  int n_err  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", nm, n, act, exp);
    end
  endtask

  // Pot device: returns resp word MSB first, next bit after every SCLK fall.
  logic [15:0] resp_next = 16'hFE80;
  logic [15:0] s_resp    = 16'h0000;
  int          s_idx     = 0;
  bit          s_active  = 1'b0;
  bit          s_prev_sc = 1'b0;

  always @(negedge clk) begin
    if (bus.pot_cs_) begin
      s_active  = 1'b0;
      s_idx     = 0;
      s_prev_sc = 1'b0;
      bus.pot_miso = 1'b0;
    end else begin
      if (!s_active) begin
        s_active = 1'b1;
        s_resp   = resp_next;
        s_idx    = 0;
      end else if (s_prev_sc && !bus.pot_sclk) begin
        s_idx++;
      end
      s_prev_sc = bus.pot_sclk;
      bus.pot_miso = (s_idx < 16) ? s_resp[15 - s_idx] : 1'b0;
    end
  end

  // Reference: each accepted request has a frame start edge S; every output is a
  // function of k = edge - S.
  bit          m_acc = 1'b0, m_wait = 1'b0;
  int          m_s = 0, k = 0, p = 0;
  logic [15:0] m_cmd = '0;
  logic        e_busy, e_active, e_cs_n, e_sclk, e_done, e_err = 1'b0, e_mosi, mosi_chk;
  logic [8:0]  e_data = '0;

  int          done_cnt = 0, done_edge = 0, mon_edges = 0;
  logic [15:0] mon_word = '0, last_word = '0;
  bit          mon_abort = 1'b1, prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(posedge clk) begin
    n++;
    e_active = 1'b0; e_cs_n = 1'b1; e_sclk = 1'b0; e_done = 1'b0;
    e_mosi   = 1'b0; mosi_chk = 1'b0;
    if (!rst_) begin
      m_acc = 1'b0; m_wait = 1'b0; e_data = '0; e_err = 1'b0; mosi_chk = 1'b1;
    end else begin
      if (!m_acc && bus.rd_req) begin
        m_acc = 1'b1;
        m_cmd = {bus.rd_addr, 2'b11, 10'h3FF};
        if (bus.pot_busy) m_wait = 1'b1;
        else              m_s = n;
      end else if (m_acc && m_wait && !bus.pot_busy) begin
        m_wait = 1'b0;
        m_s    = n;
      end
      if (m_acc && !m_wait) begin
        k = n - m_s;
        e_active = (k >= 1) && (k <= 35 * H);
        e_cs_n   = !((k >= 1) && (k <= 34 * H));
        if ((k >= 1) && (k <= H)) begin
          mosi_chk = 1'b1; e_mosi = m_cmd[15];
        end
        if ((k >= 1 + H) && (k < 1 + 33 * H)) begin
          p = k - 1 - H;
          e_sclk = ((p / H) % 2 == 0);
          if (e_sclk) begin
            mosi_chk = 1'b1; e_mosi = m_cmd[15 - p / (2 * H)];
          end
        end
        if (k == 35 * H + 1) begin
          e_done = 1'b1;
          m_acc  = 1'b0;
          if (s_resp[9]) begin e_data = s_resp[8:0]; e_err = 1'b0; end
          else           e_err = 1'b1;
        end
      end
    end
    e_busy = m_acc;
    #1;
    chk("rd_busy",   32'(bus.rd_busy),   32'(e_busy));
    chk("rd_active", 32'(bus.rd_active), 32'(e_active));
    chk("pot_cs_",   32'(bus.pot_cs_),   32'(e_cs_n));
    chk("pot_sclk",  32'(bus.pot_sclk),  32'(e_sclk));
    chk("rd_done",   32'(bus.rd_done),   32'(e_done));
    chk("rd_data",   32'(bus.rd_data),   32'(e_data));
    chk("rd_err",    32'(bus.rd_err),    32'(e_err));
    if (mosi_chk) chk("pot_mosi", 32'(bus.pot_mosi), 32'(e_mosi));
    if (!rst_) begin
      mon_abort = 1'b1;
    end else begin
      if (prev_cs && !bus.pot_cs_) begin
        mon_word = '0; mon_edges = 0; mon_abort = 1'b0;
      end
      if (!bus.pot_cs_ && bus.pot_sclk && !prev_sclk) begin
        mon_word = {mon_word[14:0], bus.pot_mosi};
        mon_edges++;
      end
      if (!prev_cs && bus.pot_cs_ && !mon_abort) begin
        chk("sclk_edges_per_frame", 32'(mon_edges), 32'd16);
        last_word = mon_word;
      end
      if (bus.rd_done) begin
        done_cnt++;
        done_edge = n;
      end
    end
    prev_cs   = bus.pot_cs_;
    prev_sclk = bus.pot_sclk;
  end

  task automatic wait_done(input int base);
    int t = 0;
    while ((done_cnt == base) && (t < 1000)) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done_cnt != base), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] r, input logic [15:0] w,
                         input logic [8:0] d, input logic e);
    int base, e0;
    resp_next = r;
    base = done_cnt;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; e0 = n + 1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    wait_done(base);
    chk("latency",   32'(done_edge - e0), 32'd141);
    chk("mosi_word", 32'(last_word),      32'(w));
    chk("rd_data_f", 32'(bus.rd_data),    32'(d));
    chk("rd_err_f",  32'(bus.rd_err),     32'(e));
  endtask

  initial begin
    int base, e0, t;
    logic [15:0] rr;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.pot_busy = 1'b0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (3) @(negedge clk);

    do_read(4'd0, 16'hFE80, 16'h0FFF, 9'h080, 1'b0);
    do_read(4'd4, 16'hFFFF, 16'h4FFF, 9'h1FF, 1'b0);
    do_read(4'd0, 16'hFE80, 16'h0FFF, 9'h080, 1'b0);
    do_read(4'd0, 16'hFC00, 16'h0FFF, 9'h080, 1'b1);

    // Contention: pot_busy held for 50 sampled edges from the request edge.
    resp_next = 16'hFE55;
    base = done_cnt;
    @(negedge clk);
    bus.pot_busy = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 4'd1; e0 = n + 1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (49) begin
      @(negedge clk);
      chk("wait_cs_high",   32'(bus.pot_cs_),   32'd1);
      chk("wait_no_active", 32'(bus.rd_active), 32'd0);
    end
    bus.pot_busy = 1'b0;
    wait_done(base);
    chk("busy_latency", 32'(done_edge - e0), 32'd191);
    chk("busy_word",    32'(last_word),      32'h1FFF);
    chk("busy_data",    32'(bus.rd_data),    32'h055);

    // Back-to-back: requests at +10 and on the done edge are dropped, +142 is taken.
    resp_next = 16'hFE80;
    base = done_cnt;
    e0 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) e0 = n + 1;
      bus.rd_req  = (i == 0) || (i == 10) || (i == 141) || (i == 142);
      bus.rd_addr = 4'd0;
      if (i == 150) begin
        chk("b2b_first_count", 32'(done_cnt - base), 32'd1);
        chk("b2b_first_edge",  32'(done_edge - e0),  32'd141);
      end
    end
    chk("b2b_total_count", 32'(done_cnt - base), 32'd2);
    chk("b2b_second_edge", 32'(done_edge - e0),  32'd283);

    // Asynchronous reset in the 7th SCLK high phase.
    resp_next = 16'hFE80;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 4'd0;
    @(negedge clk);
    bus.rd_req = 1'b0;
    t = 0;
    while (!(!bus.pot_cs_ && bus.pot_sclk && (mon_edges == 7)) && (t < 300)) begin
      @(negedge clk);
      t++;
    end
    chk("reached_7th_sclk", 32'(mon_edges), 32'd7);
    rst_ = 1'b0;
    #1;
    chk("rst_cs_high",  32'(bus.pot_cs_),   32'd1);
    chk("rst_sclk_low", 32'(bus.pot_sclk),  32'd0);
    chk("rst_busy_low", 32'(bus.rd_busy),   32'd0);
    chk("rst_inactive", 32'(bus.rd_active), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    do_read(4'd5, 16'hFEAA, 16'h5FFF, 9'h0AA, 1'b0);

    // Random traffic, including pot_busy toggling during frames.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      bus.rd_req  = ($urandom_range(0, 24) == 0);
      bus.rd_addr = 4'($urandom);
      if ($urandom_range(0, 29) == 0) bus.pot_busy = !bus.pot_busy;
      rr = 16'($urandom);
      rr[9] = ($urandom_range(0, 3) != 0);
      resp_next = rr;
    end
    bus.rd_req = 1'b0;
    bus.pot_busy = 1'b0;
    t = 0;
    while (bus.rd_busy && (t < 1000)) begin
      @(negedge clk);
      t++;
    end
    chk("drain_idle", 32'(bus.rd_busy), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
